// File: rtl/resim_toplayici.sv
// Purpose: 4-entry pixel FIFO whose popped pixels are summed per frame, with a count of value-17 pixels.
// Latency: push to cikis_gecerli is 1 cycle (no bypass); frame totals appear 1 cycle after the last pop.
// Backpressure: giris_hazir drops while the FIFO is full; a same-cycle pop never frees space for a push.
module resim_toplayici #(
  parameter int KARE_BOYU = 8,
  parameter int DERINLIK  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       giris_gecerli,
  input  logic [4:0] filtrelenmis_resim,
  output logic       giris_hazir,
  output logic       cikis_gecerli,
  input  logic       cikis_hazir,
  output logic [4:0] cikis_veri,
  output logic [7:0] kare_toplam,
  output logic [3:0] doygun_sayac,
  output logic       kare_bitti
);

  localparam logic [2:0] DOLU       = 3'(DERINLIK);
  localparam logic [2:0] SON_INDEKS = 3'(KARE_BOYU - 1);
  localparam logic [4:0] DOYGUN_DEG = 5'd17;

  typedef enum logic {
    BEKLE = 1'b0,
    TOPLA = 1'b1
  } durum_t;

  // FIFO storage and bookkeeping
  logic [4:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_doluluk;

  // Frame accumulation state
  durum_t     r_durum;
  durum_t     w_sonraki_durum;
  logic [7:0] r_toplam;
  logic [3:0] r_doygun;
  logic [2:0] r_indeks;
  logic [7:0] r_kare_toplam;
  logic [3:0] r_doygun_sayac;
  logic       r_kare_bitti;

  logic       w_giris_hazir;
  logic       w_cikis_gecerli;
  logic [4:0] w_bas_veri;
  logic       w_push;
  logic       w_pop;
  logic       w_kare_son;
  logic       w_doygun;
  logic [7:0] w_yeni_toplam;
  logic [3:0] w_yeni_doygun;

  // Handshake qualifiers: ready depends only on stored occupancy, so a pop cannot make room
  assign w_giris_hazir   = (r_doluluk < DOLU);
  assign w_cikis_gecerli = (r_doluluk != 3'd0);
  assign w_push          = giris_gecerli & w_giris_hazir;
  assign w_pop           = cikis_gecerli & cikis_hazir;
  assign w_bas_veri      = w_cikis_gecerli ? r_mem[r_rd_ptr] : 5'd0;

  // Running totals including the pixel being popped this cycle
  assign w_doygun      = (w_bas_veri == DOYGUN_DEG);
  assign w_yeni_toplam = r_toplam + {3'b000, w_bas_veri};
  assign w_yeni_doygun = r_doygun + {3'b000, w_doygun};

  assign giris_hazir   = w_giris_hazir;
  assign cikis_gecerli = w_cikis_gecerli;
  assign cikis_veri    = w_bas_veri;
  assign kare_toplam   = r_kare_toplam;
  assign doygun_sayac  = r_doygun_sayac;
  assign kare_bitti    = r_kare_bitti;

  // Data array write; contents need no reset because the head is masked when empty
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= filtrelenmis_resim;
    end
  end

  // Pointer and occupancy update; 2-bit pointers wrap naturally at depth 4
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= 2'd0;
      r_rd_ptr  <= 2'd0;
      r_doluluk <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_doluluk <= r_doluluk + 3'd1;
        2'b01:   r_doluluk <= r_doluluk - 3'd1;
        default: r_doluluk <= r_doluluk;
      endcase
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_durum <= BEKLE;
    else     r_durum <= w_sonraki_durum;
  end

  // Frame FSM next-state: leave BEKLE on a non-final pop, return on the final pop
  always_comb begin
    w_sonraki_durum = r_durum;
    case (r_durum)
      BEKLE:   if (w_pop && !w_kare_son) w_sonraki_durum = TOPLA;
      TOPLA:   if (w_kare_son)           w_sonraki_durum = BEKLE;
      default: w_sonraki_durum = BEKLE;
    endcase
  end

  // Frame FSM outputs: in BEKLE the index is zero, so a single-pixel frame completes on every pop
  always_comb begin
    w_kare_son = 1'b0;
    case (r_durum)
      BEKLE:   w_kare_son = w_pop && (SON_INDEKS == 3'd0);
      TOPLA:   w_kare_son = w_pop && (r_indeks == SON_INDEKS);
      default: w_kare_son = 1'b0;
    endcase
  end

  // Accumulators and published frame results; results hold until the next frame completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_toplam       <= 8'd0;
      r_doygun       <= 4'd0;
      r_indeks       <= 3'd0;
      r_kare_toplam  <= 8'd0;
      r_doygun_sayac <= 4'd0;
      r_kare_bitti   <= 1'b0;
    end else begin
      r_kare_bitti <= 1'b0;
      if (w_kare_son) begin
        r_kare_toplam  <= w_yeni_toplam;
        r_doygun_sayac <= w_yeni_doygun;
        r_kare_bitti   <= 1'b1;
        r_toplam       <= 8'd0;
        r_doygun       <= 4'd0;
        r_indeks       <= 3'd0;
      end else if (w_pop) begin
        r_toplam <= w_yeni_toplam;
        r_doygun <= w_yeni_doygun;
        r_indeks <= r_indeks + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_resim_toplayici.sv
// Purpose: randomized and directed checking of resim_toplayici against a queue-based frame model.
// Latency: inputs driven on the falling edge, outputs compared 1 time unit later.
// Backpressure: both FIFO sides are exercised, including full/empty corner cases.
module tb_resim_toplayici;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, 8 pixels per frame
  logic       rst = 1'b1;
  logic       gv = 1'b0;
  logic [4:0] gd = 5'd0;
  logic       ch = 1'b0;
  logic       giris_hazir, cikis_gecerli, kare_bitti;
  logic [4:0] cikis_veri;
  logic [7:0] kare_toplam;
  logic [3:0] doygun_sayac;

  resim_toplayici #(.KARE_BOYU(8), .DERINLIK(4)) dut (
    .clk(clk), .rst(rst),
    .giris_gecerli(gv), .filtrelenmis_resim(gd), .giris_hazir(giris_hazir),
    .cikis_gecerli(cikis_gecerli), .cikis_hazir(ch), .cikis_veri(cikis_veri),
    .kare_toplam(kare_toplam), .doygun_sayac(doygun_sayac), .kare_bitti(kare_bitti)
  );

  // Second instance, single-pixel frames
  logic       rst1 = 1'b1;
  logic       gv1 = 1'b0;
  logic [4:0] gd1 = 5'd0;
  logic       ch1 = 1'b0;
  logic       giris_hazir1, cikis_gecerli1, kare_bitti1;
  logic [4:0] cikis_veri1;
  logic [7:0] kare_toplam1;
  logic [3:0] doygun_sayac1;

  resim_toplayici #(.KARE_BOYU(1), .DERINLIK(4)) dut1 (
    .clk(clk), .rst(rst1),
    .giris_gecerli(gv1), .filtrelenmis_resim(gd1), .giris_hazir(giris_hazir1),
    .cikis_gecerli(cikis_gecerli1), .cikis_hazir(ch1), .cikis_veri(cikis_veri1),
    .kare_toplam(kare_toplam1), .doygun_sayac(doygun_sayac1), .kare_bitti(kare_bitti1)
  );

  int n_check = 0;
  int n_fail  = 0;

  task automatic kontrol(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: a queue of waiting pixels plus frame totals
  localparam int KB = 8;
  logic [4:0] m_q[$];
  int m_sum = 0, m_sat = 0, m_idx = 0, m_toplam = 0, m_doygun = 0;
  bit m_bitti = 1'b0;

  // One clock: drive at the falling edge, compare, let the edge happen, advance the model
  task automatic adim(input logic r, input logic v, input logic [4:0] d, input logic h);
    bit push, pop;
    logic [4:0] x;
    rst = r; gv = v; gd = d; ch = h;
    #1;
    kontrol("giris_hazir",   giris_hazir,   (m_q.size() < 4));
    kontrol("cikis_gecerli", cikis_gecerli, (m_q.size() > 0));
    kontrol("cikis_veri",    cikis_veri,    (m_q.size() > 0) ? m_q[0] : 5'd0);
    kontrol("kare_toplam",   kare_toplam,   m_toplam);
    kontrol("doygun_sayac",  doygun_sayac,  m_doygun);
    kontrol("kare_bitti",    kare_bitti,    m_bitti);
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_sum = 0; m_sat = 0; m_idx = 0; m_toplam = 0; m_doygun = 0; m_bitti = 1'b0;
    end else begin
      push = v && (m_q.size() < 4);
      pop  = h && (m_q.size() > 0);
      m_bitti = 1'b0;
      if (pop) begin
        x = m_q.pop_front();
        m_sum += x;
        if (x == 5'd17) m_sat++;
        m_idx++;
        if (m_idx == KB) begin
          m_toplam = m_sum; m_doygun = m_sat; m_bitti = 1'b1;
          m_sum = 0; m_sat = 0; m_idx = 0;
        end
      end
      if (push) m_q.push_back(d);
    end
    @(negedge clk);
  endtask

  // Drain the FIFO and check how many entries it held
  task automatic bosalt(input int beklenen, input string tag);
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      if (cikis_gecerli) n++;
      adim(1'b0, 1'b0, 5'd0, 1'b1);
    end
    kontrol(tag, n, beklenen);
  endtask

  logic [4:0] dizi34 [8];
  logic [4:0] rd;

  initial begin
    dizi34 = '{5'd17, 5'd17, 5'd6, 5'd4, 5'd2, 5'd0, 5'd17, 5'd6};
    @(negedge clk);

    // Reset state
    adim(1'b1, 1'b0, 5'd0, 1'b0);
    kontrol("rst_hazir",   giris_hazir,   1);
    kontrol("rst_gecerli", cikis_gecerli, 0);
    kontrol("rst_veri",    cikis_veri,    0);

    // Fill, reject a fifth push, drain in order
    for (int i = 0; i < 4; i++) adim(1'b0, 1'b1, 5'(2 * i), 1'b0);
    kontrol("dolu_hazir", giris_hazir, 0);
    adim(1'b0, 1'b1, 5'd17, 1'b0);
    for (int i = 0; i < 4; i++) begin
      kontrol("sira_veri", cikis_veri, 2 * i);
      adim(1'b0, 1'b0, 5'd0, 1'b1);
    end
    kontrol("besinci_yok", cikis_gecerli, 0);

    // Streaming frame with three saturated pixels
    adim(1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 8; i++) adim(1'b0, 1'b1, dizi34[i], 1'b1);
    adim(1'b0, 1'b0, 5'd0, 1'b1);
    kontrol("kare_bitti_1", kare_bitti,   1);
    kontrol("toplam_69",    kare_toplam,  69);
    kontrol("doygun_3",     doygun_sayac, 3);
    adim(1'b0, 1'b0, 5'd0, 1'b1);
    kontrol("kare_bitti_0", kare_bitti,   0);
    kontrol("toplam_tut",   kare_toplam,  69);
    kontrol("doygun_tut",   doygun_sayac, 3);

    // Simultaneous push and pop with two entries resident
    adim(1'b1, 1'b0, 5'd0, 1'b0);
    adim(1'b0, 1'b1, 5'd9, 1'b0);
    adim(1'b0, 1'b1, 5'd21, 1'b0);
    for (int i = 0; i < 10; i++) adim(1'b0, 1'b1, 5'($urandom_range(0, 31)), 1'b1);
    bosalt(2, "ayni_anda_doluluk");

    // Full FIFO with push and pop requested together
    adim(1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 1; i <= 4; i++) adim(1'b0, 1'b1, 5'(i), 1'b0);
    adim(1'b0, 1'b1, 5'd17, 1'b1);
    kontrol("dolu_pop_bas", cikis_veri, 2);
    bosalt(3, "dolu_pop_doluluk");

    // Reset in the middle of a frame
    adim(1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 6; i++) adim(1'b0, 1'b1, 5'(i + 1), 1'b1);
    adim(1'b1, 1'b0, 5'd0, 1'b0);
    kontrol("orta_rst_hazir",   giris_hazir,   1);
    kontrol("orta_rst_gecerli", cikis_gecerli, 0);
    kontrol("orta_rst_veri",    cikis_veri,    0);
    kontrol("orta_rst_toplam",  kare_toplam,   0);
    kontrol("orta_rst_doygun",  doygun_sayac,  0);
    kontrol("orta_rst_bitti",   kare_bitti,    0);
    for (int i = 0; i < 8; i++) adim(1'b0, 1'b1, 5'd2, 1'b1);
    adim(1'b0, 1'b0, 5'd0, 1'b1);
    kontrol("ikiler_bitti",  kare_bitti,   1);
    kontrol("ikiler_toplam", kare_toplam,  16);
    kontrol("ikiler_doygun", doygun_sayac, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rd = ($urandom_range(0, 3) == 0) ? 5'd17 : 5'($urandom_range(0, 31));
      adim(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rd,
           ($urandom_range(0, 2) != 0));
    end

    // Single-pixel frames on the second instance
    rst1 = 1'b1; gv1 = 1'b0; ch1 = 1'b0;
    @(negedge clk);
    rst1 = 1'b0; gv1 = 1'b1; gd1 = 5'd17; ch1 = 1'b1;
    @(negedge clk);
    gd1 = 5'd4;
    @(negedge clk);
    gv1 = 1'b0;
    #1;
    kontrol("k1_bitti_a",  kare_bitti1,   1);
    kontrol("k1_toplam_a", kare_toplam1,  17);
    kontrol("k1_doygun_a", doygun_sayac1, 1);
    @(negedge clk);
    #1;
    kontrol("k1_bitti_b",  kare_bitti1,   1);
    kontrol("k1_toplam_b", kare_toplam1,  4);
    kontrol("k1_doygun_b", doygun_sayac1, 0);
    @(negedge clk);
    #1;
    kontrol("k1_bitti_c",  kare_bitti1,   0);
    kontrol("k1_toplam_c", kare_toplam1,  4);
    kontrol("k1_bos",      cikis_gecerli1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_check, n_fail);
    $finish;
  end

endmodule

// File: doc/resim_toplayici.md
RESIM_TOPLAYICI -- requirements
Module: resim_toplayici

Interface
REQ-001 Parameter KARE_BOYU, default 8: pixels per frame; legal range 1..8.
REQ-002 Parameter DERINLIK, default 4: FIFO depth in entries; fixed at 4 for this revision.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 giris_gecerli  input  1  upstream presents a filtered pixel this cycle.
REQ-006 filtrelenmis_resim  input  5  filtered pixel value from the filter stage.
REQ-007 giris_hazir  output  1  block can accept a pixel this cycle.
REQ-008 cikis_gecerli  output  1  FIFO head pixel is valid on cikis_veri.
REQ-009 cikis_hazir  input  1  downstream consumes the head pixel this cycle.
REQ-010 cikis_veri  output  5  FIFO head pixel.
REQ-011 kare_toplam  output  8  sum of all pixels of the last completed frame.
REQ-012 doygun_sayac  output  4  count of pixels equal to 17 in the last completed frame.
REQ-013 kare_bitti  output  1  one-cycle pulse: kare_toplam/doygun_sayac just updated.

Function
REQ-014 Write (push) occurs on a rising edge when giris_gecerli=1 and giris_hazir=1; pixel stored at tail.
REQ-015 giris_hazir SHALL be 1 iff FIFO occupancy < 4; a pop in the same cycle does not free space for a push when full.
REQ-016 cikis_gecerli SHALL be 1 iff occupancy > 0; cikis_veri SHALL show head entry combinationally from stored data, 0 when empty.
REQ-017 Read (pop) occurs on a rising edge when cikis_gecerli=1 and cikis_hazir=1.
REQ-018 Simultaneous push and pop with 0 < occupancy < 4: occupancy unchanged, order preserved.
REQ-019 Push into empty FIFO: cikis_gecerli=1 the following cycle (1-cycle latency); no bypass.
REQ-020 Read/write pointers 2 bits, wrap 3->0; occupancy 3 bits, range 0..4.
REQ-021 Push attempt when full, or pop attempt when empty, SHALL have no effect on any state.
REQ-022 Frame FSM states: BEKLE (no pixel of current frame popped), TOPLA (1..KARE_BOYU-1 popped).
REQ-023 Each pop adds the popped 5-bit value (zero-extended) to internal 8-bit sum and increments internal pixel index; if value = 5'd17, internal saturated count increments.
REQ-024 BEKLE -> TOPLA on a pop that is not the frame's last; TOPLA -> BEKLE on the pop with index = KARE_BOYU-1; KARE_BOYU=1: stays BEKLE, every pop completes a frame.
REQ-025 On the frame-completing pop, next cycle: kare_toplam and doygun_sayac = totals including that pop, kare_bitti=1 for exactly one cycle, internal sum/count/index cleared to 0.
REQ-026 kare_toplam and doygun_sayac SHALL hold their values until the next frame completes.
REQ-027 Arithmetic is unsigned; max sum 8*31=248, no overflow possible in legal range; any 5-bit input value is accepted unchanged.
REQ-028 Pixels pushed but not yet popped do not affect frame totals.

Reset
REQ-029 With rst=1 at a rising edge: FIFO empty, pointers 0, FSM BEKLE, internal accumulators 0, kare_toplam=0, doygun_sayac=0, kare_bitti=0.
REQ-030 After reset: giris_hazir=1, cikis_gecerli=0, cikis_veri=0.
REQ-031 rst mid-frame or with FIFO non-empty SHALL discard all stored pixels and partial frame totals; no kare_bitti pulse.
REQ-032 rst has priority over simultaneous push/pop.

Verification
REQ-033 Reset, then push 4 pixels (0,2,4,6) with cikis_hazir=0 -> giris_hazir=0 after 4th push, 5th push (17) ignored, pops return 0,2,4,6 in order.
REQ-034 Push 8 pixels 17,17,6,4,2,0,17,6 with cikis_hazir=1 -> one cycle after 8th pop kare_bitti=1, kare_toplam=69, doygun_sayac=3; next cycle kare_bitti=0, values held.
REQ-035 FIFO holding 2 entries, push and pop in same cycle for 10 cycles -> occupancy stays 2, output order equals input order.
REQ-036 Full FIFO, giris_gecerli=1 and cikis_hazir=1 same cycle -> pop occurs, push rejected, occupancy 3.
REQ-037 Pop 5 of 8 pixels of a frame, assert rst -> all outputs at reset values, next full 8-pixel frame of 2s gives kare_toplam=16, doygun_sayac=0.
REQ-038 KARE_BOYU=1, pop 17 then 4 -> kare_bitti pulses twice; kare_toplam=17/doygun_sayac=1, then 4/0.
